// File: rtl/comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: state encoding
// and the counter-width helper.
package comparator_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmp  = 2'd1,
    StRes  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return res;
  endfunction

  // Counter width for the default operand width; instances recompute from their own N.
  localparam int unsigned DefaultN = 8;
  localparam int unsigned CNT_W    = clog2(DefaultN + 1);

endpackage

// File: rtl/serial_ge_comparator.sv
// Bit-serial MSB-first unsigned comparator: accepts N beats of (x_bit, y_bit)
// and presents registered ge/gt/eq flags through a valid/ready result port.
module serial_ge_comparator
  import comparator_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     x_bit,
  input  logic                     y_bit,
  input  logic                     abort,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     ge,
  output logic                     gt,
  output logic                     eq,
  output logic [clog2(N+1)-1:0]    bit_cnt
);

  localparam int unsigned CntW = clog2(N + 1);

  if (N < 2 || N > 32) begin : gen_param_check
    $error("serial_ge_comparator: N must be in 2..32");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              decided_q, decided_d;
  logic              x_wins_q, x_wins_d;
  logic              res_valid_q, res_valid_d;
  logic              ge_q, ge_d, gt_q, gt_d, eq_q, eq_d;
  logic              dec_upd, xw_upd;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    decided_d   = decided_q;
    x_wins_d    = x_wins_q;
    res_valid_d = res_valid_q;
    ge_d        = ge_q;
    gt_d        = gt_q;
    eq_d        = eq_q;
    cnt_inc     = cnt_q + CntW'(1);
    // First differing bit (MSB first) decides; later bits cannot change it.
    dec_upd     = decided_q | (x_bit ^ y_bit);
    xw_upd      = decided_q ? x_wins_q : (x_bit & ~y_bit);

    case (state_q)
      StIdle, StCmp: begin
        if (abort) begin
          state_d   = StIdle;
          cnt_d     = '0;
          decided_d = 1'b0;
          x_wins_d  = 1'b0;
        end else if (in_valid) begin
          state_d   = StCmp;
          cnt_d     = cnt_inc;
          decided_d = dec_upd;
          x_wins_d  = xw_upd;
          if (cnt_inc == CntW'(N)) begin
            state_d     = StRes;
            res_valid_d = 1'b1;
            gt_d        = dec_upd & xw_upd;
            eq_d        = ~dec_upd;
            ge_d        = (dec_upd & xw_upd) | ~dec_upd;
          end
        end
      end
      StRes: begin
        // abort is deliberately ignored here: a valid result is always delivered.
        if (res_ready) begin
          state_d     = StIdle;
          cnt_d       = '0;
          decided_d   = 1'b0;
          x_wins_d    = 1'b0;
          res_valid_d = 1'b0;
          ge_d        = 1'b0;
          gt_d        = 1'b0;
          eq_d        = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      decided_q   <= 1'b0;
      x_wins_q    <= 1'b0;
      res_valid_q <= 1'b0;
      ge_q        <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      decided_q   <= decided_d;
      x_wins_q    <= x_wins_d;
      res_valid_q <= res_valid_d;
      ge_q        <= ge_d;
      gt_q        <= gt_d;
      eq_q        <= eq_d;
    end
  end

  assign in_ready  = (state_q != StRes);
  assign res_valid = res_valid_q;
  assign ge        = ge_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_ge_comparator.sv
// Self-checking bench for serial_ge_comparator: directed scenarios plus random
// words checked against integer comparison of the whole operands.
module tb_serial_ge_comparator;

  localparam int N = 8;
  localparam int CntW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            x_bit = 1'b0;
  logic            y_bit = 1'b0;
  logic            abort = 1'b0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic            ge, gt, eq;
  logic [CntW-1:0] bit_cnt;

  int total = 0;
  int bad   = 0;

  serial_ge_comparator #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_bit     (x_bit),
    .y_bit     (y_bit),
    .abort     (abort),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .ge        (ge),
    .gt        (gt),
    .eq        (eq),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_bit_cnt"}, bit_cnt, 0);
    chk({tag, "_flags"}, {ge, gt, eq}, 3'b000);
  endtask

  // Streams one word MSB first, optionally pausing after beat gap_after.
  task automatic send_word(input logic [N-1:0] x, input logic [N-1:0] y,
                           input int gap_after, input int gap_len);
    for (int b = 1; b <= N; b++) begin
      in_valid = 1'b1;
      x_bit    = x[N-b];
      y_bit    = y[N-b];
      chk("in_ready_beat", in_ready, 1);
      tick();
      in_valid = 1'b0;
      if (b < N) begin
        chk("bit_cnt", bit_cnt, b);
        chk("no_early_res", res_valid, 0);
      end else begin
        chk("res_latency", res_valid, 1);
        chk("bit_cnt_full", bit_cnt, N);
      end
      if (b == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("gap_hold", bit_cnt, b);
        end
      end
    end
  endtask

  // Collects a result after holding res_ready low for `hold` cycles.
  task automatic get_result(input logic [N-1:0] x, input logic [N-1:0] y, input int hold);
    logic [2:0] exp_f;
    exp_f = {(int'(x) >= int'(y)), (int'(x) > int'(y)), (int'(x) == int'(y))};
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_flags", {ge, gt, eq}, exp_f);
      tick();
    end
    res_ready = 1'b1;
    chk("res_valid", res_valid, 1);
    chk("res_flags", {ge, gt, eq}, exp_f);
    tick();
    res_ready = 1'b0;
    chk_idle("handoff");
  endtask

  initial begin
    logic [N-1:0] rx, ry;

    // Reset values
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;

    // 1: 0xA5 vs 0x3C, no gaps
    send_word(8'hA5, 8'h3C, 0, 0);
    get_result(8'hA5, 8'h3C, 0);

    // 2: equal words with a 3-cycle gap after beat 4
    send_word(8'h5A, 8'h5A, 4, 3);
    get_result(8'h5A, 8'h5A, 0);

    // 3: decided at MSB, consumer stalls 5 cycles
    send_word(8'h7F, 8'h80, 0, 0);
    get_result(8'h7F, 8'h80, 5);

    // 4: abort after beat 5; the beat presented with abort is dropped
    rx = 8'hFF;
    ry = 8'h00;
    for (int b = 1; b <= 5; b++) begin
      in_valid = 1'b1;
      x_bit = rx[N-b];
      y_bit = ry[N-b];
      tick();
    end
    chk("pre_abort_cnt", bit_cnt, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk_idle("abort");
    send_word(8'h01, 8'h02, 0, 0);
    get_result(8'h01, 8'h02, 0);

    // abort is ignored once the result is valid
    send_word(8'h90, 8'h91, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_res", res_valid, 1);
    get_result(8'h90, 8'h91, 0);

    // 5: reset mid-CMP after a decided MSB, then an equal word must report eq
    rx = 8'hE0;
    for (int b = 1; b <= 3; b++) begin
      in_valid = 1'b1;
      x_bit = rx[N-b];
      y_bit = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_cmp");
    send_word(8'h22, 8'h22, 0, 0);
    get_result(8'h22, 8'h22, 0);

    // reset mid-RES
    send_word(8'h33, 8'h12, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_res");
    send_word(8'h12, 8'h33, 0, 0);
    get_result(8'h12, 8'h33, 0);

    // 6: back-to-back; next MSB offered during the handoff must not be taken
    send_word(8'h10, 8'h0F, 0, 0);
    res_ready = 1'b1;
    in_valid  = 1'b1;
    x_bit     = 1'b0;
    y_bit     = 1'b0;
    chk("b2b_in_ready_res", in_ready, 0);
    chk("b2b_first_gt", {ge, gt, eq}, 3'b110);
    tick();
    res_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_no_accept", bit_cnt, 0);
    chk("b2b_cleared", res_valid, 0);
    send_word(8'h00, 8'h00, 0, 0);
    get_result(8'h00, 8'h00, 0);

    // Random words, gaps and consumer stalls
    for (int i = 0; i < 30; i++) begin
      rx = N'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? rx : N'($urandom);
      send_word(rx, ry, $urandom_range(0, N - 1), $urandom_range(0, 3));
      get_result(rx, ry, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_ge_comparator.md
Name: serial_ge_comparator

Overview:
- Bit-serial magnitude comparator. Two N-bit unsigned operands x and y arrive one bit per accepted beat, MSB first, through a valid/ready stream.
- After N beats it reports x>=y, plus gt and eq, through a valid/ready result port.
- It is the sequential sink-side counterpart to the combinational x>=y comparator. It sits between a serial operand source and any consumer of the compare flag.

Parameters:
- N, 8, operand width in bits (beats per word); legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  x_bit/y_bit valid this cycle
- in_ready  output  1  block can accept a beat
- x_bit  input  1  current bit of x, MSB first
- y_bit  input  1  current bit of y, MSB first
- abort  input  1  discard the word in progress
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- ge  output  1  x >= y
- gt  output  1  x > y
- eq  output  1  x == y
- bit_cnt  output  clog2(N+1)  beats accepted in current word

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, sampled on the rising edge of clk, and has priority over all other inputs.
- Reset values: state=IDLE; in_ready=1; res_valid=0; ge=0; gt=0; eq=0; bit_cnt=0; internal decided=0; internal x_wins=0.
- Beat acceptance: a beat is accepted when in_valid && in_ready at a rising edge.
- IDLE state:
  - in_ready=1.
  - An accepted beat is the MSB. It sets bit_cnt=1, goes to CMP, and updates the decision with that beat.
- CMP state:
  - in_ready=1.
  - Each accepted beat increments bit_cnt.
  - Decision update: if decided==0 and x_bit!=y_bit, then decided<=1 and x_wins<=x_bit.
  - Once decided, later bits are ignored for the result; they are still counted.
- CMP to RES transition: when the accepted beat makes bit_cnt==N, go to RES on the next edge.
  - Present gt=decided&x_wins, eq=~decided, ge=gt|eq, res_valid=1.
  - Latency: res_valid rises in the cycle after the Nth beat is accepted.
- RES state:
  - in_ready=0.
  - ge/gt/eq are held stable while res_valid=1 and res_ready=0.
  - On res_valid && res_ready, go to IDLE. This clears res_valid, bit_cnt, decided and x_wins. ge/gt/eq return to 0.
  - No beat is accepted in the handoff cycle; the next word can start the cycle after.
- abort:
  - In IDLE or CMP, abort returns to IDLE and clears bit_cnt, decided and x_wins.
  - A beat presented in the same cycle as abort is dropped.
  - In RES, abort is ignored; a result, once valid, is always delivered.
- in_valid low: in_valid low mid-word stalls with no state change; gaps of any length are legal.
- N==1 is not supported; parameter check is a simulation-time error.
- Output timing: all outputs are registered; there is no combinational path from inputs to outputs except none (in_ready is decoded from the state register).

Decomposition:
- Shared package comparator_pkg holds:
  - state encoding constants IDLE=2'd0, CMP=2'd1, RES=2'd2;
  - function clog2;
  - localparam CNT_W = clog2(N+1).
- No sub-module is required. The bit counter is inline.

Test Plan:
1. N=8, stream x=0xA5, y=0x3C with no gaps, res_ready=1 → res_valid high the cycle after beat 8; gt=1, eq=0, ge=1; bit_cnt reaches 8.
2. x=0x5A, y=0x5A, with in_valid deasserted for 3 cycles after beat 4 → eq=1, gt=0, ge=1; bit_cnt holds at 4 during the gap.
3. x=0x7F, y=0x80 (decided at MSB), with res_ready held 0 for 5 cycles → ge=0, gt=0, eq=0 held stable; in_ready=0 throughout; result handed off when res_ready rises.
4. Assert abort after beat 5 of x=0xFF, y=0x00, then stream x=0x01, y=0x02 → single result ge=0, gt=0; no result from the aborted word.
5. Assert rst mid-CMP (beat 3) and mid-RES → next cycle state IDLE, res_valid=0, bit_cnt=0, in_ready=1.
6. Back-to-back words: 0x10 vs 0x0F, then 0x00 vs 0x00, with res_ready=1 → results gt=1, then eq=1; second word's MSB is accepted no earlier than one cycle after the first handoff.
